// File: rtl/reduce_pipe_if.sv
// Valid/ready bus for reduce_pipe: beat input side and per-packet result side.
// out_beats exists only when REDUCE_PIPE_CNT_EN is defined.
interface reduce_pipe_if #(
    parameter int WIDTH    = 11,
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      in_last;
    logic [1:0]                in_op;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS-1:0]       out_y;
`ifdef REDUCE_PIPE_CNT_EN
    logic [CNT_W-1:0]          out_beats;
`endif

    modport master (
        output in_valid, in_data, in_last, in_op, out_ready,
`ifdef REDUCE_PIPE_CNT_EN
        input  out_beats,
`endif
        input  in_ready, out_valid, out_y
    );

    modport slave (
        input  in_valid, in_data, in_last, in_op, out_ready,
`ifdef REDUCE_PIPE_CNT_EN
        output out_beats,
`endif
        output in_ready, out_valid, out_y
    );
endinterface

// File: rtl/reduce_pipe.sv
// Per-lane AND/NAND/OR/XOR reduction accumulated over packet beats.
// Optional saturating beat counter enabled by REDUCE_PIPE_CNT_EN.
module reduce_pipe #(
    parameter int WIDTH    = 11,
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    reduce_pipe_if.slave   bus
);
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    state_t              state_q, state_d;
    logic [CHANNELS-1:0] acc_q, acc_d;
    logic [CHANNELS-1:0] y_q, y_d;
    logic [CHANNELS-1:0] beat_red, merged;
    logic [1:0]          op_q, op_d, op_eff;
    logic                valid_q, valid_d;
    logic                accept;

    assign bus.in_ready  = ~valid_q | bus.out_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_y     = y_q;
    assign accept        = bus.in_valid & bus.in_ready;
    // The first beat of a packet supplies its own op.
    assign op_eff        = (state_q == IDLE) ? bus.in_op : op_q;

    always_comb begin
        beat_red = '0;
        merged   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            unique case (op_eff)
                OP_OR:   beat_red[k] = |bus.in_data[k*WIDTH +: WIDTH];
                OP_XOR:  beat_red[k] = ^bus.in_data[k*WIDTH +: WIDTH];
                default: beat_red[k] = &bus.in_data[k*WIDTH +: WIDTH];
            endcase
            if (state_q == IDLE) begin
                merged[k] = beat_red[k];
            end else begin
                unique case (op_eff)
                    OP_OR:   merged[k] = acc_q[k] | beat_red[k];
                    OP_XOR:  merged[k] = acc_q[k] ^ beat_red[k];
                    default: merged[k] = acc_q[k] & beat_red[k];
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        y_d     = y_q;
        valid_d = valid_q & ~bus.out_ready;
        if (accept) begin
            if (bus.in_last) begin
                state_d = IDLE;
                valid_d = 1'b1;
                y_d     = (op_eff == OP_NAND) ? ~merged : merged;
            end else begin
                state_d = ACCUM;
                acc_d   = merged;
                op_d    = op_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= OP_AND;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

`ifdef REDUCE_PIPE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_base, cnt_next;
    logic [CNT_W-1:0] beats_q;

    // A fresh packet counts from zero regardless of the stale counter.
    assign cnt_base      = (state_q == IDLE) ? '0 : cnt_q;
    assign cnt_next      = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
    assign bus.out_beats = beats_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            beats_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_next;
            if (bus.in_last) beats_q <= cnt_next;
        end
    end
`endif
endmodule

// File: tb/tb_reduce_pipe.sv
// Self-checking bench for reduce_pipe: directed cases plus randomized
// traffic against a bit-counting reference model.
module tb_reduce_pipe;
    localparam int W  = 11;
    localparam int CH = 2;
`ifdef REDUCE_PIPE_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reduce_pipe_if #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) bus ();

    reduce_pipe #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [CH*W-1:0] d,
                         input logic l, input logic [1:0] op,
                         input logic r);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.in_op     = op;
        bus.out_ready = r;
    endtask

    function automatic logic [W-1:0] gen_lane();
        case ($urandom % 3)
            0:       return '1;
            1:       return '0;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(0, '0, 0, 2'b00, 0);
        drive(0, '0, 0, 2'b00, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out_y !== 2'b00) begin
            errors++;
            $display("FAIL reset_y got %b want 00", bus.out_y);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
`ifdef REDUCE_PIPE_CNT_EN
        checks++;
        if (bus.out_beats !== '0) begin
            errors++;
            $display("FAIL reset_beats got %0d want 0", bus.out_beats);
        end
`endif
    endtask

    task automatic test_single_and();
        drive(1, {11'h7FE, 11'h7FF}, 1, 2'b00, 1);
        drive(0, '0, 0, 2'b00, 1);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_valid got %b want 1", bus.out_valid);
        end
        checks++;
        if (bus.out_y !== 2'b01) begin
            errors++;
            $display("FAIL single_y got %b want 01", bus.out_y);
        end
        drive(0, '0, 0, 2'b00, 1);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_clear got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_xor_multi();
        drive(1, {11'h000, 11'h001}, 0, 2'b11, 1);
        drive(1, {11'h000, 11'h003}, 0, 2'b11, 1);
        drive(1, {11'h000, 11'h000}, 1, 2'b11, 1);
        drive(0, '0, 0, 2'b00, 1);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_y !== 2'b01) begin
            errors++;
            $display("FAIL xor_multi got v=%b y=%b want v=1 y=01",
                     bus.out_valid, bus.out_y);
        end
`ifdef REDUCE_PIPE_CNT_EN
        checks++;
        if (bus.out_beats !== 2'd3) begin
            errors++;
            $display("FAIL xor_beats got %0d want 3", bus.out_beats);
        end
`endif
        drive(0, '0, 0, 2'b00, 1);
    endtask

    task automatic test_nand_op_ignore();
        drive(1, {11'h7FF, 11'h7FF}, 0, 2'b01, 1);
        drive(1, {11'h000, 11'h7FF}, 1, 2'b10, 1);
        drive(0, '0, 0, 2'b00, 1);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_y !== 2'b10) begin
            errors++;
            $display("FAIL nand_ignore got v=%b y=%b want v=1 y=10",
                     bus.out_valid, bus.out_y);
        end
        drive(0, '0, 0, 2'b00, 1);
    endtask

    task automatic test_backpressure();
        drive(1, {11'h010, 11'h000}, 1, 2'b10, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, {11'h7FF, 11'h7FF}, 1, 2'b00, 0);
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_in_ready[%0d] got %b want 0",
                         i, bus.in_ready);
            end
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_y !== 2'b10) begin
                errors++;
                $display("FAIL stall_hold[%0d] got v=%b y=%b want v=1 y=10",
                         i, bus.out_valid, bus.out_y);
            end
        end
        drive(1, {11'h7FF, 11'h7FF}, 1, 2'b00, 1);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready got %b want 1", bus.in_ready);
        end
        drive(0, '0, 0, 2'b00, 1);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_y !== 2'b11) begin
            errors++;
            $display("FAIL reload got v=%b y=%b want v=1 y=11",
                     bus.out_valid, bus.out_y);
        end
        drive(0, '0, 0, 2'b00, 1);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reload_clear got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_packet();
        drive(1, {11'h000, 11'h001}, 0, 2'b10, 1);
        drive(1, {11'h000, 11'h000}, 0, 2'b10, 1);
        drive(0, '0, 0, 2'b00, 1);
        rst = 1'b1;
        drive(0, '0, 0, 2'b00, 1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 0, 2'b00, 1);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_pulse[%0d] got %b want 0",
                         i, bus.out_valid);
            end
        end
        drive(1, {11'h010, 11'h000}, 1, 2'b10, 1);
        drive(0, '0, 0, 2'b00, 1);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_y !== 2'b10) begin
            errors++;
            $display("FAIL post_rst_or got v=%b y=%b want v=1 y=10",
                     bus.out_valid, bus.out_y);
        end
        drive(0, '0, 0, 2'b00, 1);
    endtask

`ifdef REDUCE_PIPE_CNT_EN
    task automatic test_beat_saturation();
        for (int i = 0; i < 5; i++) drive(1, '1, 0, 2'b00, 1);
        drive(1, '1, 1, 2'b00, 1);
        drive(0, '0, 0, 2'b00, 1);
        #1;
        checks++;
        if (bus.out_beats !== 2'd3 || bus.out_y !== 2'b11) begin
            errors++;
            $display("FAIL beat_sat got beats=%0d y=%b want beats=3 y=11",
                     bus.out_beats, bus.out_y);
        end
        drive(0, '0, 0, 2'b00, 1);
    endtask
`endif

    task automatic run_random(input int n, input int pv, input int pr,
                              input int maxlen, output int cycles);
        logic [CH-1:0]   exp_y[$];
        int              exp_b[$];
        logic [CH*W-1:0] d;
        logic [W-1:0]    lane;
        logic [CH-1:0]   all1, any1, par, ey, res;
        logic [1:0]      pop;
        int              sent, got, len, idx, eb, sat;
        bit              have;
        sent   = 0;
        got    = 0;
        len    = 0;
        idx    = 0;
        have   = 0;
        pop    = 2'b00;
        d      = '0;
        all1   = '1;
        any1   = '0;
        par    = '0;
        sat    = (1 << CW) - 1;
        cycles = 0;
        while (got < n && cycles < 5000) begin
            @(negedge clk);
            cycles++;
            bus.out_ready = ($urandom % 100) < pr;
            if (!have && sent < n) begin
                len  = $urandom_range(1, maxlen);
                idx  = 0;
                pop  = 2'($urandom);
                all1 = '1;
                any1 = '0;
                par  = '0;
                have = 1;
                for (int k = 0; k < CH; k++) d[k*W +: W] = gen_lane();
            end
            bus.in_valid = have && (($urandom % 100) < pv);
            bus.in_data  = d;
            bus.in_last  = (idx == len - 1);
            bus.in_op    = (idx == 0) ? pop : 2'($urandom);
            #1;
            checks++;
            if (bus.in_ready !== (~bus.out_valid | bus.out_ready)) begin
                errors++;
                $display("FAIL in_ready_rule got %b want %b", bus.in_ready,
                         ~bus.out_valid | bus.out_ready);
            end
            if (bus.out_valid && bus.out_ready) begin
                got++;
                checks++;
                if (exp_y.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious got y=%b want no result",
                             bus.out_y);
                end else begin
                    ey = exp_y.pop_front();
                    eb = exp_b.pop_front();
                    if (bus.out_y !== ey) begin
                        errors++;
                        $display("FAIL rand_y[%0d] got %b want %b",
                                 got, bus.out_y, ey);
                    end
`ifdef REDUCE_PIPE_CNT_EN
                    checks++;
                    if (int'(bus.out_beats) != eb) begin
                        errors++;
                        $display("FAIL rand_beats[%0d] got %0d want %0d",
                                 got, bus.out_beats, eb);
                    end
`endif
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                for (int k = 0; k < CH; k++) begin
                    lane = d[k*W +: W];
                    if (lane != '1) all1[k] = 1'b0;
                    if (lane != '0) any1[k] = 1'b1;
                    if ($countones(lane) % 2 == 1) par[k] = ~par[k];
                end
                idx++;
                if (idx == len) begin
                    case (pop)
                        2'b00:   res = all1;
                        2'b01:   res = ~all1;
                        2'b10:   res = any1;
                        default: res = par;
                    endcase
                    exp_y.push_back(res);
                    exp_b.push_back(len < sat ? len : sat);
                    sent++;
                    have = 0;
                end else begin
                    for (int k = 0; k < CH; k++) d[k*W +: W] = gen_lane();
                end
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL rand_timeout got %0d results want %0d", got, n);
        end
    endtask

    task automatic test_random();
        int cyc;
        run_random(60, 70, 60, 5, cyc);
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_random(16, 100, 100, 1, cyc);
        checks++;
        if (cyc != 17) begin
            errors++;
            $display("FAIL b2b_cycles got %0d want 17", cyc);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_op     = 2'b00;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_and();
        test_xor_multi();
        test_nand_op_ignore();
        test_backpressure();
        test_reset_mid_packet();
`ifdef REDUCE_PIPE_CNT_EN
        test_beat_saturation();
`endif
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
